pkt_counter_poller: RTL and testbench

//  AXI4-Lite master that reads a bank of 64-bit packet counters, each stored as a

---
 rtl/pkt_counter_poller.sv | 225 ++++++++++++++++++++++
 tb/tb_pkt_counter_poller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_counter_poller.sv
// rtl/pkt_counter_poller.sv - AXI4-Lite master that sweeps HIGH/LOW counter pairs and streams tear-free 64-bit values
// Each counter is read H1, L, H2 (plus L2 when HIGH moved) so a LOW wrap between reads is never reported.
module pkt_counter_poller #(
    parameter int AW        = 8,
    parameter int BASE_ADDR = 0,
    parameter int NUM_CTR   = 7
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [63:0]   ctr_tdata,
    output logic [7:0]    ctr_tid,
    output logic          ctr_tuser,
    output logic          ctr_tvalid,
    input  logic          ctr_tready,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic [2:0]    M_AXI_AWPROT,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_EMIT} state_t;
    typedef enum logic [1:0] {P_H1, P_L1, P_H2, P_L2} phase_t;

    localparam logic [7:0]    LAST_K = 8'(NUM_CTR - 1);
    localparam logic [AW-1:0] BASE   = AW'(BASE_ADDR);

    state_t        state_q;
    phase_t        phase_q;
    logic [7:0]    k_q;
    logic [31:0]   h1_q;
    logic [31:0]   l_q;
    logic [31:0]   h2_q;
    logic          ctr_err_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [63:0]   tdata_q;
    logic [7:0]    tid_q;
    logic          tuser_q;
    logic          tvalid_q;
    logic [AW-1:0] araddr_q;
    logic          arvalid_q;
    logic          rready_q;

    logic [7:0]    next_k_d;
    logic [AW-1:0] addr_hi_d;
    logic [AW-1:0] addr_lo_d;
    logic [AW-1:0] addr_next_d;
    logic          ar_hs_d;
    logic          r_hs_d;
    logic          emit_hs_d;
    logic          resp_bad_d;

    // Register index = 2k + lo; byte address wraps modulo 2^AW.
    function automatic logic [AW-1:0] reg_addr(input logic [7:0] k, input logic lo);
        logic [8:0] idx;
        idx = {k, lo};
        return BASE + AW'({idx, 2'b00});
    endfunction

    always_comb begin
        next_k_d    = k_q + 8'd1;
        addr_hi_d   = reg_addr(k_q, 1'b0);
        addr_lo_d   = reg_addr(k_q, 1'b1);
        addr_next_d = reg_addr(next_k_d, 1'b0);
        ar_hs_d     = arvalid_q && M_AXI_ARREADY;
        r_hs_d      = rready_q && M_AXI_RVALID;
        emit_hs_d   = tvalid_q && ctr_tready;
        resp_bad_d  = (M_AXI_RRESP != 2'b00);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            phase_q   <= P_H1;
            k_q       <= '0;
            h1_q      <= '0;
            l_q       <= '0;
            h2_q      <= '0;
            ctr_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tdata_q   <= '0;
            tid_q     <= '0;
            tuser_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q     <= 1'b0;
                        k_q       <= '0;
                        busy_q    <= 1'b1;
                        ctr_err_q <= 1'b0;
                        phase_q   <= P_H1;
                        araddr_q  <= reg_addr(8'd0, 1'b0);
                        arvalid_q <= 1'b1;
                        state_q   <= S_AR;
                    end
                end
                S_AR: begin
                    if (ar_hs_d) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (r_hs_d) begin
                        rready_q <= 1'b0;
                        if (resp_bad_d) begin
                            err_q     <= 1'b1;
                            ctr_err_q <= 1'b1;
                        end
                        case (phase_q)
                            P_H1: begin
                                h1_q      <= M_AXI_RDATA;
                                phase_q   <= P_L1;
                                araddr_q  <= addr_lo_d;
                                arvalid_q <= 1'b1;
                                state_q   <= S_AR;
                            end
                            P_L1: begin
                                l_q       <= M_AXI_RDATA;
                                phase_q   <= P_H2;
                                araddr_q  <= addr_hi_d;
                                arvalid_q <= 1'b1;
                                state_q   <= S_AR;
                            end
                            P_H2: begin
                                h2_q <= M_AXI_RDATA;
                                if (M_AXI_RDATA == h1_q) begin
                                    tdata_q  <= {h1_q, l_q};
                                    tid_q    <= k_q;
                                    tuser_q  <= ctr_err_q || resp_bad_d;
                                    tvalid_q <= 1'b1;
                                    state_q  <= S_EMIT;
                                end else begin
                                    // HIGH moved during the pair: LOW must be re-read against H2.
                                    phase_q   <= P_L2;
                                    araddr_q  <= addr_lo_d;
                                    arvalid_q <= 1'b1;
                                    state_q   <= S_AR;
                                end
                            end
                            default: begin
                                tdata_q  <= {h2_q, M_AXI_RDATA};
                                tid_q    <= k_q;
                                tuser_q  <= ctr_err_q || resp_bad_d;
                                tvalid_q <= 1'b1;
                                state_q  <= S_EMIT;
                            end
                        endcase
                    end
                end
                default: begin
                    if (emit_hs_d) begin
                        tvalid_q <= 1'b0;
                        if (k_q == LAST_K) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            k_q       <= next_k_d;
                            ctr_err_q <= 1'b0;
                            phase_q   <= P_H1;
                            araddr_q  <= addr_next_d;
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end
                    end
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign ctr_tdata     = tdata_q;
    assign ctr_tid       = tid_q;
    assign ctr_tuser     = tuser_q;
    assign ctr_tvalid    = tvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;

    // Read-only master: write channels are parked idle.
    assign M_AXI_AWADDR  = '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = '0;
    assign M_AXI_WSTRB   = 4'b0000;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;

    logic unused_write_inputs;
    assign unused_write_inputs = &{1'b0, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID};

endmodule

// File: tb/tb_pkt_counter_poller.sv
// tb/tb_pkt_counter_poller.sv - scoreboard bench for pkt_counter_poller with a reactive AXI4-Lite read slave
module tb_pkt_counter_poller;

    localparam int AW      = 8;
    localparam int NUM_CTR = 7;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  tid;
        logic        tuser;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          ctr_tready = 1'b1;
    logic          M_AXI_ARREADY = 1'b0;
    logic [31:0]   M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = '0;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_AWREADY = 1'b0;
    logic          M_AXI_WREADY = 1'b0;
    logic [1:0]    M_AXI_BRESP = '0;
    logic          M_AXI_BVALID = 1'b0;

    logic          busy, done, err, ctr_tuser, ctr_tvalid;
    logic [63:0]   ctr_tdata;
    logic [7:0]    ctr_tid;
    logic [AW-1:0] M_AXI_ARADDR, M_AXI_AWADDR;
    logic          M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY;
    logic [2:0]    M_AXI_ARPROT, M_AXI_AWPROT;
    logic [31:0]   M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;

    pkt_counter_poller #(.AW(AW), .BASE_ADDR(0), .NUM_CTR(NUM_CTR)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .err(err),
        .ctr_tdata(ctr_tdata), .ctr_tid(ctr_tid), .ctr_tuser(ctr_tuser),
        .ctr_tvalid(ctr_tvalid), .ctr_tready(ctr_tready),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave personality and scoreboard state
    int mode = 1;
    bit twist_k0 = 1'b0;
    int err_idx = -1;
    int ar_delay = 0;
    int r_delay = 0;
    int stall_k = -1;
    int stall_len = 10;
    int stall_cnt = 0;
    int rd_cnt[64];
    int ar_cnt = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] ar_log[$];
    beat_t sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_val(input int idx, input int cnt);
        int k;
        bit lo;
        k  = idx / 2;
        lo = (idx % 2) == 1;
        if (mode == 1) return lo ? 32'h2 : 32'h1;
        if (twist_k0 && k == 0) return lo ? (cnt == 0 ? 32'hFFFF_FFFF : 32'h3) : (cnt == 0 ? 32'h5 : 32'h6);
        return lo ? 32'hA000_0000 + 32'(k * 3) : 32'h100 + 32'(k);
    endfunction

    function automatic logic [63:0] exp_val(input int k);
        if (mode == 1) return 64'h1_0000_0002;
        if (twist_k0 && k == 0) return 64'h6_0000_0003;
        return {32'h100 + 32'(k), 32'hA000_0000 + 32'(k * 3)};
    endfunction

    // Reactive slave, stream-ready driver and output monitor, all sampled on the falling edge.
    initial begin : slave
        bit ar_hs_n, r_hs_n, have_r, ar_waiting;
        int ar_wait, r_wait, idx;
        logic [AW-1:0] rd_addr, held_addr, hs_addr;
        logic [63:0] stall_data;
        beat_t b;
        ar_hs_n = 0; r_hs_n = 0; have_r = 0; ar_waiting = 0; ar_wait = 0; r_wait = 0;
        rd_addr = '0; held_addr = '0; hs_addr = '0; stall_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID  = 1'b0;
                ctr_tready    = 1'b1;
                ar_hs_n = 0; r_hs_n = 0; have_r = 0; ar_waiting = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (r_hs_n) begin
                    M_AXI_RVALID = 1'b0;
                    have_r = 0;
                end
                if (ar_hs_n) begin
                    have_r = 1; r_wait = 0; rd_addr = hs_addr;
                    ar_cnt++;
                    ar_log.push_back(hs_addr);
                    ar_waiting = 0; ar_wait = 0;
                end
                if (ar_waiting) check_eq("arvalid_hold", 64'(M_AXI_ARVALID), 64'd1);
                if (M_AXI_ARVALID) begin
                    if (ar_waiting) check_eq("araddr_hold", 64'(M_AXI_ARADDR), 64'(held_addr));
                    else begin
                        ar_waiting = 1;
                        held_addr = M_AXI_ARADDR;
                        check_eq("one_outstanding", 64'(have_r), 64'd0);
                    end
                end
                M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= ar_delay);
                if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_wait++;
                if (have_r && !M_AXI_RVALID) begin
                    if (r_wait >= r_delay) begin
                        idx = int'(rd_addr) >> 2;
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = slave_val(idx, rd_cnt[idx]);
                        M_AXI_RRESP  = (idx == err_idx) ? 2'b11 : 2'b00;
                        rd_cnt[idx]++;
                    end else r_wait++;
                end
                if (stall_k >= 0 && ctr_tvalid && int'(ctr_tid) == stall_k && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) stall_data = ctr_tdata;
                    else check_eq("stall_tdata", ctr_tdata, stall_data);
                    check_eq("stall_no_ar", 64'(M_AXI_ARVALID), 64'd0);
                    ctr_tready = 1'b0;
                    stall_cnt++;
                end else ctr_tready = 1'b1;
                if (ctr_tvalid && ctr_tready) begin
                    beat_cnt++;
                    if (sb_q.size() == 0) check_eq("beat_unexpected", 64'(sb_q.size()), 64'd1);
                    else begin
                        b = sb_q.pop_front();
                        check_eq("tdata", ctr_tdata, b.data);
                        check_eq("tid", 64'(ctr_tid), 64'(b.tid));
                        check_eq("tuser", 64'(ctr_tuser), 64'(b.tuser));
                    end
                end
                if (done) done_cnt++;
                ar_hs_n = M_AXI_ARVALID && M_AXI_ARREADY;
                hs_addr = M_AXI_ARADDR;
                r_hs_n  = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    end

    task automatic start_sweep();
        beat_t b;
        for (int i = 0; i < 64; i++) rd_cnt[i] = 0;
        for (int k = 0; k < NUM_CTR; k++) begin
            b.data  = exp_val(k);
            b.tid   = 8'(k);
            b.tuser = (err_idx == 2 * k) || (err_idx == 2 * k + 1);
            sb_q.push_back(b);
        end
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("err_cleared_on_start", 64'(err), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #3;
            if (done_cnt != d0) break;
        end
        check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
        check_eq("busy_low_at_done", 64'(busy), 64'd0);
    endtask

    task automatic settle_and_check(input string tag);
        int d0;
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        #3;
        check_eq({tag, "_done_once"}, 64'(done_cnt - d0), 64'd0);
        check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : main
        int a0, b0, l0, i;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_tvalid", 64'(ctr_tvalid), 64'd0);
        check_eq("rst_tdata", ctr_tdata, 64'd0);
        check_eq("rst_tid_tuser", 64'({ctr_tid, ctr_tuser}), 64'd0);
        check_eq("rst_ar", 64'({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT}), 64'd0);
        check_eq("rst_rready", 64'(M_AXI_RREADY), 64'd0);
        check_eq("wr_idle", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'd1);
        @(negedge clk); #2 resetn = 1'b1;

        // 1: constant counters, free-flowing slave
        mode = 1; a0 = ar_cnt; b0 = beat_cnt;
        start_sweep();
        wait_done(400);
        check_eq("t1_err", 64'(err), 64'd0);
        check_eq("t1_ars", 64'(ar_cnt - a0), 64'd21);
        check_eq("t1_beats", 64'(beat_cnt - b0), 64'd7);
        settle_and_check("t1");

        // 2: HIGH of counter 0 moves between H1 and H2
        mode = 0; twist_k0 = 1'b1; a0 = ar_cnt; l0 = ar_log.size();
        start_sweep();
        wait_done(400);
        check_eq("t2_ars", 64'(ar_cnt - a0), 64'd22);
        check_eq("t2_ar0", 64'(ar_log[l0]), 64'h00);
        check_eq("t2_ar1", 64'(ar_log[l0 + 1]), 64'h04);
        check_eq("t2_ar2", 64'(ar_log[l0 + 2]), 64'h00);
        check_eq("t2_ar3", 64'(ar_log[l0 + 3]), 64'h04);
        check_eq("t2_ar4", 64'(ar_log[l0 + 4]), 64'h08);
        settle_and_check("t2");
        twist_k0 = 1'b0;

        // 3: DECERR on LOW of counter 2
        err_idx = 5;
        start_sweep();
        wait_done(400);
        check_eq("t3_err_held", 64'(err), 64'd1);
        settle_and_check("t3");
        check_eq("t3_err_sticky", 64'(err), 64'd1);
        err_idx = -1;

        // 4: downstream stall on counter 3 (start also checks err is cleared)
        stall_k = 3; stall_len = 10; stall_cnt = 0; b0 = beat_cnt;
        start_sweep();
        wait_done(600);
        check_eq("t4_stall_len", 64'(stall_cnt), 64'd10);
        check_eq("t4_beats", 64'(beat_cnt - b0), 64'd7);
        settle_and_check("t4");
        stall_k = -1;

        // 5: slow ARREADY, start pulses while busy are dropped
        ar_delay = 5; b0 = beat_cnt;
        start_sweep();
        for (int p = 0; p < 2; p++) begin
            repeat (30) @(negedge clk);
            #2;
            check_eq("t5_busy_at_pulse", 64'(busy), 64'd1);
            start = 1'b1;
            @(negedge clk); #2 start = 1'b0;
        end
        wait_done(1500);
        check_eq("t5_beats", 64'(beat_cnt - b0), 64'd7);
        settle_and_check("t5");
        ar_delay = 0;

        // 6: reset while waiting for read data
        r_delay = 30;
        start_sweep();
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (M_AXI_RREADY) break;
        end
        check_eq("t6_reached_wait_r", 64'(M_AXI_RREADY), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_rready", 64'(M_AXI_RREADY), 64'd0);
        check_eq("t6_ar", 64'({M_AXI_ARVALID, M_AXI_ARADDR}), 64'd0);
        check_eq("t6_stream", 64'({ctr_tvalid, ctr_tuser, ctr_tid}), 64'd0);
        check_eq("t6_tdata", ctr_tdata, 64'd0);
        check_eq("t6_done_err", 64'({done, err}), 64'd0);
        sb_q.delete();
        a0 = ar_cnt;
        repeat (3) @(negedge clk);
        #1 check_eq("t6_no_ar_in_reset", 64'(ar_cnt - a0), 64'd0);
        r_delay = 0;
        @(negedge clk); #2 resetn = 1'b1;
        l0 = ar_log.size(); b0 = beat_cnt;
        start_sweep();
        wait_done(400);
        check_eq("t6_restart_ars", 64'(ar_log.size() - l0), 64'd21);
        check_eq("t6_restart_addr0", 64'(ar_log[l0]), 64'h00);
        check_eq("t6_beats", 64'(beat_cnt - b0), 64'd7);
        settle_and_check("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
